imem_loader: RTL and testbench

- Writer side of the instruction-memory interface: the core only reads imem, and this block fills it.
- Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words and writes them sequentially into imem from address 0.
- Holds the core in reset while loading and releases it when the load completes.
- Sits beside the processor top: drives the imem write port and the core's active-high reset.

---
 rtl/imem_loader_pkg.sv | 15 +
 rtl/imem_loader_if.sv | 30 +++
 rtl/imem_loader_byte_packer.sv | 44 ++++
 rtl/imem_loader.sv | 160 ++++++++++++++++
 tb/tb_imem_loader.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the imem loader.
package imem_loader_pkg;
  localparam int LEN_W          = 16;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_DONE,
    S_ERR,
    S_CSUM
  } state_e;
endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake and imem write-port bundles.
interface imem_loader_byte_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready
  );
  modport slave (
    input  byte_valid, byte_data,
    output byte_ready
  );
endinterface

interface imem_loader_wr_if #(
  parameter int ADDR_W = 6
);
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output imem_we, imem_addr, imem_wdata
  );
  modport slave (
    input  imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Assembles little-endian 32-bit words from accepted bytes.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  din_i,
  output logic        last_o,
  output logic        word_valid_o,
  output logic [31:0] word_o
);
  logic [1:0]  idx_q;
  logic [23:0] acc_q;
  logic [31:0] word_q;
  logic        vld_q;

  assign last_o =
    en_i && (idx_q == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      acc_q  <= '0;
      word_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= last_o;
      if (clr_i)
        idx_q <= '0;
      else if (en_i)
        idx_q <= idx_q + 2'd1;
      // newest byte enters at the top, so byte 0 ends up in [7:0]
      if (en_i)
        acc_q <= {din_i, acc_q[23:8]};
      if (last_o)
        word_q <= {din_i, acc_q};
    end
  end

  assign word_valid_o = vld_q;
  assign word_o       = word_q;
endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed image into imem, holding the core in reset.
// Optional: define LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W      = 6,
  parameter int DEPTH_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  imem_loader_byte_if.slave bs,
  imem_loader_wr_if.master  wr,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        err
);
  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  n_full;
  logic              accept;
  logic              data_en;
  logic              pk_clr;
  logic              pk_last;
  logic              pk_valid;
  logic [31:0]       pk_word;
  logic              last_word;
  logic              ready;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  assign accept    = bs.byte_valid && ready;
  assign data_en   = accept && (state_q == S_DATA);
  assign n_full    = {bs.byte_data, len_q[7:0]};
  assign last_word =
    (LEN_W'(wcnt_q) == (len_q - 16'd1));

  imem_loader_byte_packer u_packer (
    .clk          (clk),
    .rst_n        (reset),
    .clr_i        (pk_clr),
    .en_i         (data_en),
    .din_i        (bs.byte_data),
    .last_o       (pk_last),
    .word_valid_o (pk_valid),
    .word_o       (pk_word)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wcnt_d    = wcnt_q;
    pk_clr    = 1'b0;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    cpu_reset = 1'b1;
`ifdef LOADER_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LEN0;
      end
      S_LEN0: begin
        ready = 1'b1;
        busy  = 1'b1;
        if (accept) begin
          len_d[7:0] = bs.byte_data;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        ready = 1'b1;
        busy  = 1'b1;
        if (accept) begin
          len_d  = n_full;
          wcnt_d = '0;
          pk_clr = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          csum_d = '0;
`endif
          if (n_full == '0 ||
              n_full > LEN_W'(DEPTH_WORDS))
            state_d = S_ERR;
          else
            state_d = S_DATA;
        end
      end
      S_DATA: begin
        ready = 1'b1;
        busy  = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        if (accept) csum_d = csum_q ^ bs.byte_data;
`endif
        // counter stops on the last word so it never wraps
        if (pk_last) begin
          if (last_word)
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          else
            wcnt_d = wcnt_q + 1'b1;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        ready = 1'b1;
        busy  = 1'b1;
        if (accept)
          state_d = (bs.byte_data == csum_q) ?
                    S_DONE : S_ERR;
      end
`endif
      S_DONE: begin
        done      = 1'b1;
        cpu_reset = 1'b0;
        if (start) state_d = S_LEN0;
      end
      S_ERR: begin
        err = 1'b1;
        if (start) state_d = S_LEN0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      wcnt_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      if (pk_last) addr_q <= wcnt_q;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) csum_q <= '0;
    else        csum_q <= csum_d;
  end
`endif

  assign bs.byte_ready = ready;
  assign wr.imem_we    = pk_valid;
  assign wr.imem_addr  = addr_q;
  assign wr.imem_wdata = pk_word;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard.
module tb_imem_loader;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic cpu_reset, busy, done, err;

  imem_loader_byte_if bif ();
  imem_loader_wr_if #(.ADDR_W(6)) wif ();

  imem_loader #(
    .ADDR_W      (6),
    .DEPTH_WORDS (64)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bs        (bif.slave),
    .wr        (wif.master),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int          errs = 0;
  int          checks = 0;
  int          wr_cnt = 0;
  int          wr0;
  logic [37:0] exp_q[$];
  logic [7:0]  csum_acc;

  task automatic chk(input string tag,
                     input logic [37:0] obs,
                     input logic [37:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (wif.imem_we === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0)
        chk("unexpected_wr",
            38'(exp_q.size()), 38'd1);
      else
        chk("wr_addr_data",
            {wif.imem_addr, wif.imem_wdata},
            exp_q.pop_front());
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input bit gap);
    bit ok, rdy;
    ok = 1'b0;
    if (gap) wait_cyc(1);
    bif.byte_valid = 1'b1;
    bif.byte_data  = b;
    for (int t = 0; t < 200; t++) begin
      rdy = bif.byte_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    bif.byte_valid = 1'b0;
    if (!ok) chk("accept_timeout", 38'd0, 38'd1);
  endtask

  task automatic send_len(input logic [15:0] n,
                          input bit gap);
    csum_acc = '0;
    send_byte(n[7:0], gap);
    send_byte(n[15:8], gap);
  endtask

  task automatic send_word(input logic [31:0] w,
                           input logic [5:0] a,
                           input bit gap,
                           input bit is_last);
    exp_q.push_back({a, w});
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8], gap);
      csum_acc ^= w[8*k +: 8];
    end
    chk("we_latency", 38'(wif.imem_we), 38'd1);
`ifdef LOADER_CHECKSUM_EN
    if (is_last)
      chk("csum_state", 38'({busy, done}), 38'b10);
`else
    if (is_last)
      chk("done_with_last_we",
          38'({done, cpu_reset}), 38'b10);
`endif
  endtask

  task automatic finish_load(input bit gap);
`ifdef LOADER_CHECKSUM_EN
    send_byte(csum_acc, gap);
`else
    if (gap) wait_cyc(1);
`endif
  endtask

  task automatic two_word_load(input bit gap);
    wr0 = wr_cnt;
    send_len(16'd2, gap);
    send_word(32'h1234_5678, 6'd0, gap, 1'b0);
    send_word(32'hDEAD_BEEF, 6'd1, gap, 1'b1);
    finish_load(gap);
    wait_cyc(3);
    chk("load_end",
        38'({done, err, cpu_reset, busy}), 38'b1000);
    chk("load_wr_cnt", 38'(wr_cnt - wr0), 38'd2);
    chk("load_q_empty", 38'(exp_q.size()), 38'd0);
  endtask

  initial begin
    bif.byte_valid = 1'b0;
    bif.byte_data  = '0;
    #22;
    chk("rst_outputs",
        38'({cpu_reset, busy, done, err,
             wif.imem_we, bif.byte_ready}),
        38'b100000);
    chk("rst_bus",
        {wif.imem_addr, wif.imem_wdata}, 38'd0);
    reset = 1'b1;
    wait_cyc(2);

    // basic load, valid held high
    pulse_start();
    chk("len0_busy", 38'({busy, cpu_reset}), 38'b11);
    two_word_load(1'b0);

    // reload from DONE with valid toggling
    pulse_start();
    chk("reassert_from_done",
        38'({cpu_reset, done, busy}), 38'b101);
    two_word_load(1'b1);

    // zero length
    pulse_start();
    wr0 = wr_cnt;
    send_len(16'h0000, 1'b0);
    wait_cyc(2);
    chk("len0_err",
        38'({err, cpu_reset, busy, done}), 38'b1100);
    chk("len0_no_wr", 38'(wr_cnt - wr0), 38'd0);

    // length beyond capacity, started from ERR
    pulse_start();
    chk("err_clears", 38'({err, cpu_reset}), 38'b01);
    send_len(16'h0041, 1'b0);
    wait_cyc(2);
    chk("len41_err",
        38'({err, cpu_reset, busy, done}), 38'b1100);
    chk("len41_no_wr", 38'(wr_cnt - wr0), 38'd0);

    // asynchronous reset in the middle of word 1
    pulse_start();
    wr0 = wr_cnt;
    send_len(16'd2, 1'b0);
    send_word(32'hA5A5_0F0F, 6'd0, 1'b0, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    reset = 1'b0;
    #2;
    chk("midrst_outputs",
        38'({cpu_reset, busy, bif.byte_ready,
             wif.imem_we}),
        38'b1000);
    wait_cyc(3);
    reset = 1'b1;
    wait_cyc(5);
    chk("midrst_wr_cnt", 38'(wr_cnt - wr0), 38'd1);
    chk("midrst_q_empty", 38'(exp_q.size()), 38'd0);
    chk("midrst_idle",
        38'({done, err, busy, cpu_reset}), 38'b0001);

    // full-depth load from IDLE
    pulse_start();
    wr0 = wr_cnt;
    send_len(16'h0040, 1'b0);
    for (int i = 0; i < 64; i++)
      send_word($urandom, 6'(i), 1'b0, i == 63);
    finish_load(1'b0);
    wait_cyc(3);
    chk("full_end",
        38'({done, err, cpu_reset, busy}), 38'b1000);
    chk("full_wr_cnt", 38'(wr_cnt - wr0), 38'd64);
    chk("full_q_empty", 38'(exp_q.size()), 38'd0);

`ifdef LOADER_CHECKSUM_EN
    pulse_start();
    send_len(16'd1, 1'b0);
    send_word(32'h0804_0201, 6'd0, 1'b0, 1'b1);
    send_byte(8'h0F, 1'b0);
    wait_cyc(2);
    chk("csum_ok",
        38'({done, err, cpu_reset}), 38'b100);

    pulse_start();
    send_len(16'd1, 1'b0);
    send_word(32'h0804_0201, 6'd0, 1'b0, 1'b1);
    send_byte(8'h0E, 1'b0);
    wait_cyc(2);
    chk("csum_bad",
        38'({done, err, cpu_reset}), 38'b011);
    chk("csum_q_empty", 38'(exp_q.size()), 38'd0);
`endif

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end
endmodule
